// File: rtl/dram_cache_mem_slave.sv
// Memory-side slave model of the DRAM holding the DRAM-cache tag+data store.
// One entry per cache index, each a 64-bit tag word plus a 512-bit data block.
module dram_cache_mem_slave #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int TAG_S    = 64,
  parameter int ID_W     = 16,
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         arid_i,
  input  logic [ADDR_W-1:0]       araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_W-1:0]         rid_o,
  output logic [TAG_S+DATA_W-1:0] rdata_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic [ID_W-1:0]         awid_i,
  input  logic [ADDR_W-1:0]       awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_W-1:0]         wid_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_W-1:0]         bid_o,
  output logic                    bvalid_o,
  input  logic                    bready_i
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} rd_state_t;

  logic [TAG_S-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  written;

  // Address bits outside the index and the tag/data selector carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wid_i, araddr_i[ADDR_W-1:6+DEPTH_W], araddr_i[5:0],
                         awaddr_i[ADDR_W-2:6+DEPTH_W], awaddr_i[5:0]};

  // ---------------- write path ----------------
  logic [ID_W-1:0]    aw_id_q;
  logic [DEPTH_W-1:0] aw_idx_q;
  logic               aw_tag_q;
  logic [DATA_W-1:0]  w_data_q;

  logic               aw_fire, w_fire, commit;
  logic [ID_W-1:0]    c_id;
  logic [DEPTH_W-1:0] c_idx;
  logic               c_tag;
  logic [DATA_W-1:0]  c_data;

  assign aw_fire = awvalid_i && awready_o;
  assign w_fire  = wvalid_i && wready_o;
  // A channel whose ready is low has already been captured for the pending write.
  assign commit  = (aw_fire || w_fire) && (aw_fire || !awready_o) && (w_fire || !wready_o);
  assign c_id    = aw_fire ? awid_i : aw_id_q;
  assign c_idx   = aw_fire ? awaddr_i[6 +: DEPTH_W] : aw_idx_q;
  assign c_tag   = aw_fire ? awaddr_i[ADDR_W-1] : aw_tag_q;
  assign c_data  = w_fire ? wdata_i : w_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_o <= 1'b1;
      wready_o  <= 1'b1;
      bvalid_o  <= 1'b0;
      bid_o     <= '0;
      aw_id_q   <= '0;
      aw_idx_q  <= '0;
      aw_tag_q  <= 1'b0;
      w_data_q  <= '0;
      written   <= '0;
    end else begin
      if (aw_fire) begin
        awready_o <= 1'b0;
        aw_id_q   <= awid_i;
        aw_idx_q  <= awaddr_i[6 +: DEPTH_W];
        aw_tag_q  <= awaddr_i[ADDR_W-1];
      end
      if (w_fire) begin
        wready_o <= 1'b0;
        w_data_q <= wdata_i;
      end
      if (commit) begin
        bvalid_o       <= 1'b1;
        bid_o          <= c_id;
        written[c_idx] <= 1'b1;
      end
      if (bvalid_o && bready_i) begin
        bvalid_o  <= 1'b0;
        awready_o <= 1'b1;
        wready_o  <= 1'b1;
      end
    end
  end

  // NOTE: the storage arrays are not reset; the written bits alone define what reads back as zero.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (c_tag) begin
        tag_mem[c_idx] <= c_data[TAG_S-1:0];
        if (!written[c_idx]) data_mem[c_idx] <= '0;
      end else begin
        data_mem[c_idx] <= c_data;
        if (!written[c_idx]) tag_mem[c_idx] <= '0;
      end
    end
  end

  // Simulation backdoor loaders.
  task automatic write_8byte(input logic [DEPTH_W-1:0] index, input logic [TAG_S-1:0] value);
    tag_mem[index] <= value;
    if (!written[index]) data_mem[index] <= '0;
    written[index] <= 1'b1;
  endtask

  task automatic write_64byte(input logic [DEPTH_W-1:0] index, input logic [DATA_W-1:0] value);
    data_mem[index] <= value;
    if (!written[index]) tag_mem[index] <= '0;
    written[index] <= 1'b1;
  endtask

  // ---------------- read path ----------------
  rd_state_t          rd_state;
  logic [CNT_W-1:0]   rd_cnt;
  logic [ID_W-1:0]    ar_id_q;
  logic [DEPTH_W-1:0] ar_idx_q;
  logic [TAG_S-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;

  // A write committing on the sampling edge is forwarded so it is visible to the read.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_tag  = written[ar_idx_q] ? tag_mem[ar_idx_q]  : '0;
    rd_data = written[ar_idx_q] ? data_mem[ar_idx_q] : '0;
    if (commit && c_idx == ar_idx_q) begin
      if (c_tag) rd_tag  = c_data[TAG_S-1:0];
      else       rd_data = c_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= IDLE;
      rd_cnt    <= '0;
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rid_o     <= '0;
      rdata_o   <= '0;
      ar_id_q   <= '0;
      ar_idx_q  <= '0;
    end else begin
      case (rd_state)
        IDLE: if (arvalid_i && arready_o) begin
          arready_o <= 1'b0;
          ar_id_q   <= arid_i;
          ar_idx_q  <= araddr_i[6 +: DEPTH_W];
          rd_cnt    <= '0;
          rd_state  <= WAIT;
        end
        WAIT: if (rd_cnt == CNT_W'(READ_LAT - 1)) begin
          rdata_o  <= {rd_tag, rd_data};
          rid_o    <= ar_id_q;
          rvalid_o <= 1'b1;
          rd_state <= RESP;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        RESP: if (rready_i) begin
          rvalid_o  <= 1'b0;
          arready_o <= 1'b1;
          rd_state  <= IDLE;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cache_mem_slave.sv
// Scoreboard bench for dram_cache_mem_slave: expected R/B beats are queued at issue
// time from a reference model and compared when the DUT responds.
module tb_dram_cache_mem_slave;

  localparam int ADDR_W = 64, DATA_W = 512, TAG_S = 64, ID_W = 16, DEPTH_W = 10, READ_LAT = 2;
  localparam int DEPTH = 1 << DEPTH_W;
  localparam int RD_W = TAG_S + DATA_W;

  logic clk = 1'b0, rst_n;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [RD_W-1:0] rdata;
  logic [DATA_W-1:0] wdata;

  dram_cache_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_S(TAG_S), .ID_W(ID_W),
    .DEPTH_W(DEPTH_W), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bvalid_o(bvalid), .bready_i(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ID_W-1:0] id; logic [RD_W-1:0] data; } rexp_t;
  rexp_t           rq[$];
  logic [ID_W-1:0] bq[$];

  logic [TAG_S-1:0]  m_tag  [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  bit                m_wr   [DEPTH];

  int n_checks = 0, n_fail = 0, b_hs = 0;

  always @(posedge clk) if (rst_n && bvalid && bready) b_hs++;

  function automatic logic [RD_W-1:0] model_read(input int idx);
    return m_wr[idx] ? {m_tag[idx], m_data[idx]} : '0;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    int idx = int'(addr[6 +: DEPTH_W]);
    if (!m_wr[idx]) begin m_tag[idx] = '0; m_data[idx] = '0; end
    if (addr[ADDR_W-1]) m_tag[idx] = d[TAG_S-1:0];
    else m_data[idx] = d;
    m_wr[idx] = 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
  endfunction

  // All tasks start and finish just after a falling edge.
  task automatic issue_ar(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
    int n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_wait: arready=%b required 1", arready); end
    araddr = addr; arid = id; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; araddr = '1;
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
    int n = 0;
    rexp_t e;
    rq.push_back('{id: id, data: model_read(int'(addr[6 +: DEPTH_W]))});
    issue_ar(addr, id);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (n !== READ_LAT) begin n_fail++; $display("FAIL %s latency: got %0d cycles required %0d", name, n, READ_LAT); end
    e = rq.pop_front();
    n_checks++;
    if (rid !== e.id) begin n_fail++; $display("FAIL %s rid: got %h required %h", name, rid, e.id); end
    n_checks++;
    if (rdata !== e.data) begin n_fail++; $display("FAIL %s rdata: got %h required %h", name, rdata, e.data); end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL %s rvalid_drop: got %b required 0", name, rvalid); end
  endtask

  // mode 0: AW and W together; 1: AW one cycle before W; 2: W one cycle before AW.
  task automatic do_write(input string name, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                          input logic [DATA_W-1:0] d, input int mode);
    int n = 0;
    logic [ID_W-1:0] eb;
    bq.push_back(id);
    model_write(addr, d);
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    awaddr = addr; awid = id; wdata = d; wid = ~id;
    if (mode == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; awaddr = '1; awid = '1;
      n_checks++;
      if (awready !== 1'b0 || bvalid !== 1'b0) begin
        n_fail++; $display("FAIL %s aw_first_hold: awready=%b bvalid=%b required 0 0", name, awready, bvalid);
      end
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
    end else begin
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0; wdata = '1;
      n_checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
        n_fail++; $display("FAIL %s w_first_hold: wready=%b bvalid=%b required 0 0", name, wready, bvalid);
      end
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    eb = bq.pop_front();
    n_checks++;
    if (bvalid !== 1'b1 || n !== 0) begin n_fail++; $display("FAIL %s bvalid: got %b after %0d cycles required 1 after 0", name, bvalid, n); end
    n_checks++;
    if (bid !== eb) begin n_fail++; $display("FAIL %s bid: got %h required %h", name, bid, eb); end
    @(negedge clk);
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL %s after_b: bvalid/awready/wready got %b required 011", name, {bvalid, awready, wready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100 || rid !== '0 || bid !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ar/aw/w_ready,rvalid,bvalid=%b rid=%h bid=%h rdata_nonzero=%b required 11100 0 0 0",
               {arready, awready, wready, rvalid, bvalid}, rid, bid, |rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    read_check("reset_read_idx3", 64'h0000_0000_0000_00c0, 16'h1234);
  endtask

  task automatic test_data_loop();
    for (int i = 0; i < 10; i++)
      do_write("loop_wr", ADDR_W'(i) << 6, ID_W'(16'h100 + i), DATA_W'(i), i % 3);
    for (int i = 0; i < 10; i++)
      read_check("loop_rd", ADDR_W'(i) << 6, ID_W'(16'h200 + i));
    read_check("index_wrap", 64'h0123_4567_89ab_0095, 16'h0bad);
  endtask

  task automatic test_tag_data();
    do_write("tag_wr", 64'h8000_0000_0000_0040, 16'ha001, DATA_W'(64'hc000_0001_c000_0000), 0);
    do_write("data_wr", 64'h0000_0000_0000_0040, 16'ha002, {DATA_W{1'b1}}, 0);
    read_check("tag_data_rd", 64'h0000_0000_0000_0040, 16'ha003);
  endtask

  task automatic test_aw_before_w();
    int b0 = b_hs;
    do_write("aw_before_w", 64'h8000_0000_0000_0100, 16'hb00b, DATA_W'(64'h8000_0000_4000_0000), 1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (b_hs !== b0 + 1 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL aw_before_w_single_b: handshakes=%0d bvalid=%b required 1 0", b_hs - b0, bvalid);
    end
    read_check("aw_before_w_rd", 64'h0000_0000_0000_0100, 16'hb00c);
  endtask

  task automatic test_read_backpressure();
    int n = 0;
    rexp_t e;
    rready = 1'b0;
    rq.push_back('{id: 16'hc0de, data: model_read(6)});
    issue_ar(64'h0000_0000_0000_0180, 16'hc0de);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    e = rq.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== e.data || rid !== e.id) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: rvalid=%b arready=%b rid=%h rdata=%h required 1 0 %h %h",
                 k, rvalid, arready, rid, rdata, e.id, e.data);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_release: rvalid=%b required 0", rvalid); end
    n = 0;
    while (!arready && n < 5) begin @(negedge clk); n++; end
    n_checks++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL stall_arready_return: arready=%b required 1", arready); end
  endtask

  task automatic test_write_on_sample_edge();
    logic [DATA_W-1:0] d = {16{32'hdead_beef}};
    rexp_t e;
    logic [ID_W-1:0] eb;
    model_write(64'h0000_0000_0000_01c0, d);
    bq.push_back(16'hd007);
    rq.push_back('{id: 16'hd008, data: model_read(7)});
    issue_ar(64'h0000_0000_0000_01c0, 16'hd008);
    repeat (READ_LAT - 1) @(negedge clk);
    awaddr = 64'h0000_0000_0000_01c0; awid = 16'hd007; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    e = rq.pop_front();
    eb = bq.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== e.data || rid !== e.id) begin
      n_fail++; $display("FAIL same_edge_read: rvalid=%b rid=%h rdata=%h required 1 %h %h", rvalid, rid, rdata, e.id, e.data);
    end
    n_checks++;
    if (bvalid !== 1'b1 || bid !== eb) begin
      n_fail++; $display("FAIL same_edge_b: bvalid=%b bid=%h required 1 %h", bvalid, bid, eb);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit seen = 1'b0;
    issue_ar(64'h0000_0000_0000_0140, 16'he001);
    #1 rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    n_checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
      n_fail++; $display("FAIL reset_in_wait_values: got %b required 11100", {arready, awready, wready, rvalid, bvalid});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvalid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_in_wait_no_resp: rvalid seen=1 required 0"); end
    read_check("reset_in_wait_idx5", 64'h0000_0000_0000_0140, 16'he002);
    read_check("reset_in_wait_idx1", 64'h0000_0000_0000_0040, 16'he003);
  endtask

  initial begin
    arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awvalid = 1'b0; wid = '0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    model_clear();
    @(negedge clk);
    test_reset();
    test_data_loop();
    test_tag_data();
    test_aw_before_w();
    test_read_backpressure();
    test_write_on_sample_edge();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
